// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multicycle control FSM for a 32-bit MIPS-like datapath. One instruction is in flight at a
//   time. Each instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB using the IR
//   opcode/funct fields, the ALU zero flag and the memory mem_ready handshake.
//
// Parameters
//   ILLEGAL_TRAP  1: an unsupported instruction parks the FSM in HALT until reset.
//                 0: the unsupported instruction is skipped and the FSM returns to FETCH.
//
// Ports
//   clk, rst             rising-edge clock; asynchronous active-high reset
//   opcode, funct        IR[31:26] and IR[5:0], valid from DECODE onward
//   zero                 ALU zero flag, used only in BRANCH
//   mem_ready            memory handshake, sampled only in FETCH, MEM_RD and MEM_WR
//   state_o              current state, for debug
//   pc_write .. halted   datapath enables and selects, combinational from the state
//
// Every output is held at zero while rst is high, so a reset during a memory access
// drops the request immediately.
module mc_control_fsm #(
  parameter int unsigned ILLEGAL_TRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state_o,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [3:0] alu_sel,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic       halted
);

  localparam logic [3:0] StFetch   = 4'd0;
  localparam logic [3:0] StDecode  = 4'd1;
  localparam logic [3:0] StMemAddr = 4'd2;
  localparam logic [3:0] StMemRd   = 4'd3;
  localparam logic [3:0] StMemWb   = 4'd4;
  localparam logic [3:0] StMemWr   = 4'd5;
  localparam logic [3:0] StRExec   = 4'd6;
  localparam logic [3:0] StRWb     = 4'd7;
  localparam logic [3:0] StBranch  = 4'd8;
  localparam logic [3:0] StJump    = 4'd9;
  localparam logic [3:0] StIExec   = 4'd10;
  localparam logic [3:0] StIWb     = 4'd11;
  localparam logic [3:0] StHalt    = 4'd12;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluLui = 4'b0101;
  localparam logic [3:0] AluSll = 4'b0110;
  localparam logic [3:0] AluSrl = 4'b0111;
  localparam logic [3:0] AluSra = 4'b1000;

  logic [3:0] state_q, state_d;
  logic       r_legal, r_shift;
  logic [3:0] r_sel;
  logic       op_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

  // R-type funct decode: ALU operation and whether the shift datapath (B, shamt) is used.
  always_comb begin
    r_legal = 1'b1;
    r_shift = 1'b0;
    r_sel   = AluAdd;
    case (funct)
      6'b100000: r_sel = AluAdd;
      6'b100010: r_sel = AluSub;
      6'b100100: r_sel = AluAnd;
      6'b100101: r_sel = AluOr;
      6'b100110: r_sel = AluXor;
      6'b000000: begin r_sel = AluSll; r_shift = 1'b1; end
      6'b000010: begin r_sel = AluSrl; r_shift = 1'b1; end
      6'b000011: begin r_sel = AluSra; r_shift = 1'b1; end
      default:   r_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OpRtype: op_legal = r_legal;
      OpLw, OpSw, OpBeq, OpBne, OpJ,
      OpAddi, OpAndi, OpOri, OpXori, OpLui: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = StFetch;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 3'b000;
    alu_sel    = AluAdd;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    halted     = 1'b0;

    case (state_q)
      StFetch: begin
        // PC + 4 goes straight back into the PC in the same cycle the IR is loaded.
        mem_read  = 1'b1;
        alu_src_b = 3'b001;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 3'b101;
        if (!op_legal) begin
          illegal = 1'b1;
          state_d = (ILLEGAL_TRAP != 0) ? StHalt : StFetch;
        end else begin
          case (opcode)
            OpRtype:      state_d = StRExec;
            OpLw, OpSw:   state_d = StMemAddr;
            OpBeq, OpBne: state_d = StBranch;
            OpJ:          state_d = StJump;
            default:      state_d = StIExec;
          endcase
        end
      end
      StRExec: begin
        alu_sel = r_sel;
        if (r_shift) begin
          alu_src_a = 2'b10;
          alu_src_b = 3'b100;
        end else begin
          alu_src_a = 2'b01;
          alu_src_b = 3'b000;
        end
        state_d = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StMemAddr: begin
        alu_src_a = 2'b01;
        alu_src_b = 3'b010;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? StFetch : StMemWr;
      end
      StBranch: begin
        alu_src_a = 2'b01;
        alu_sel   = AluSub;
        pc_source = 2'b01;
        pc_write  = (opcode == OpBeq) ? zero : ~zero;
        state_d   = StFetch;
      end
      StJump: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = StFetch;
      end
      StIExec: begin
        alu_src_a = 2'b01;
        case (opcode)
          OpAddi: begin alu_sel = AluAdd; alu_src_b = 3'b010; end
          OpAndi: begin alu_sel = AluAnd; alu_src_b = 3'b011; end
          OpOri:  begin alu_sel = AluOr;  alu_src_b = 3'b011; end
          OpXori: begin alu_sel = AluXor; alu_src_b = 3'b011; end
          OpLui:  begin alu_sel = AluLui; alu_src_a = 2'b11; alu_src_b = 3'b000; end
          default: ;
        endcase
        state_d = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end
      default: state_d = StFetch;
    endcase

    if (rst) begin
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 3'b000;
      alu_sel    = AluAdd;
      pc_source  = 2'b00;
      illegal    = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule
